// File: rtl/motor_pwm_capture.sv
// PWM/direction loopback monitor. Reports the high time, the period and the direction code of
// every complete PWM period, and flags a line that stays at one level for too long.
module motor_pwm_capture #(
  parameter int CNT_W   = 21,
  parameter int TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic [1:0]       dir_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [1:0]       dir_out,
  output logic             sample_valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [2:0] {IDLE, ARMED, HIGH, LOW, STUCK} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  state_t           state, state_next;
  logic             pwm_s1, pwm_s2, pwm_s3;
  logic [1:0]       dir_s1, dir_s2;
  logic [CNT_W-1:0] hcnt, pcnt;
  logic [1:0]       dlat;
  logic             rise, fall, expired;

  // Control strobes decoded from the state and the detected edges.
  logic start_period, restart_pcnt, inc_p, inc_h, publish, enter_stuck, leave_stuck;

  // pwm history resets high so that a line already high at reset release is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_s1 <= 1'b1;
      pwm_s2 <= 1'b1;
      pwm_s3 <= 1'b1;
      dir_s1 <= 2'b00;
      dir_s2 <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
      pwm_s1 <= pwm_in;
      pwm_s2 <= pwm_s1;
      pwm_s3 <= pwm_s2;
      dir_s1 <= dir_in;
      dir_s2 <= dir_s1;
    end
  end

  assign rise = pwm_s2 & ~pwm_s3;
  assign fall = ~pwm_s2 & pwm_s3;
  // >= also catches pcnt stepping one past the limit on a HIGH to LOW transition.
  assign expired = (pcnt >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall) state_next = ARMED;
               else if (expired) state_next = STUCK;
      ARMED:   if (rise) state_next = HIGH;
               else if (expired) state_next = STUCK;
      HIGH:    if (fall) state_next = LOW;
               else if (expired) state_next = STUCK;
      LOW:     if (rise) state_next = HIGH;
               else if (expired) state_next = STUCK;
      STUCK:   if (rise) state_next = HIGH;
               else if (fall) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every strobe gets a default first, so no path through the case infers a latch.
    start_period = 1'b0;
    restart_pcnt = 1'b0;
    inc_p        = 1'b0;
    inc_h        = 1'b0;
    publish      = 1'b0;
    enter_stuck  = 1'b0;
    leave_stuck  = 1'b0;
    case (state)
      IDLE: begin
        if (fall)         restart_pcnt = 1'b1;
        else if (expired) enter_stuck  = 1'b1;
        else              inc_p        = 1'b1;
      end
      ARMED: begin
        if (rise)         start_period = 1'b1;
        else if (expired) enter_stuck  = 1'b1;
        else              inc_p        = 1'b1;
      end
      HIGH: begin
        // The falling-edge cycle is already low time: pcnt counts it, hcnt does not.
        if (fall)         inc_p       = 1'b1;
        else if (expired) enter_stuck = 1'b1;
        else begin
          inc_p = 1'b1;
          inc_h = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          publish      = 1'b1;
          start_period = 1'b1;
        end else if (expired) enter_stuck = 1'b1;
        else                  inc_p       = 1'b1;
      end
      STUCK: begin
        if (rise) begin
          start_period = 1'b1;
          leave_stuck  = 1'b1;
        end else if (fall) begin
          restart_pcnt = 1'b1;
          leave_stuck  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt         <= '0;
      pcnt         <= '0;
      dlat         <= 2'b00;
      high_cnt     <= '0;
      period_cnt   <= '0;
      dir_out      <= 2'b00;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      sample_valid <= publish;
      if (publish) begin
        high_cnt   <= hcnt;
        period_cnt <= pcnt;
        dir_out    <= dlat;
      end
      if (start_period) begin
        hcnt <= ONE;
        pcnt <= ONE;
        dlat <= dir_s2;
      end else begin
        if (restart_pcnt)   pcnt <= ONE;
        else if (inc_p)     pcnt <= pcnt + ONE;
        if (inc_h)          hcnt <= hcnt + ONE;
      end
      if (enter_stuck) begin
        timeout     <= 1'b1;
        stuck_level <= pwm_s2;
      end else if (leave_stuck) begin
        timeout     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_capture.sv
// Self-checking bench for motor_pwm_capture: table of periodic waveforms, hand-written timeout and
// reset sequences, and a random phase scored against a sample-history reference model.
module tb_motor_pwm_capture;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [1:0]       dir_in = 2'b00;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [1:0]       dir_out;
  logic             sample_valid, timeout, stuck_level;

  motor_pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .dir_in       (dir_in),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .dir_out      (dir_out),
    .sample_valid (sample_valid),
    .timeout      (timeout),
    .stuck_level  (stuck_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Strobe log, filled by tick() whenever sample_valid is seen.
  int         str_cyc[$];
  int         str_hi[$];
  int         str_per[$];
  logic [1:0] str_dir[$];
  int         btb = 0;
  logic       last_valid = 1'b0;

  // Reference model: raw per-edge samples; a strobe is due two edges after every input rise
  // except the first, carrying the ones-count and length of the preceding rise-to-rise span.
  typedef struct { int at; int hi; int per; logic [1:0] dir; } exp_t;
  logic       m_pwm[$];
  logic [1:0] m_dir[$];
  exp_t       exp_q[$];
  int         rd = 0;
  int         m_start = 0;
  bit         have_start = 1'b0;
  bit         model_on = 1'b0;
  int         hold_hi = 0, hold_per = 0;
  logic [1:0] hold_dir = 2'b00;

  typedef struct { int h; int l; logic [1:0] dir; int reps; int exp_hi; int exp_per; } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_pwm.delete();
    m_dir.delete();
    exp_q.delete();
    rd         = 0;
    m_start    = 0;
    have_start = 1'b0;
    hold_hi    = 0;
    hold_per   = 0;
    hold_dir   = 2'b00;
  endtask

  task automatic model_push(input logic p, input logic [1:0] d);
    int   k;
    logic prev;
    exp_t e;
    k    = m_pwm.size();
    prev = (k == 0) ? 1'b1 : m_pwm[k-1];
    m_pwm.push_back(p);
    m_dir.push_back(d);
    if (p && !prev) begin
      if (have_start) begin
        e.at  = k + 2;
        e.hi  = 0;
        for (int i = m_start; i < k; i++) if (m_pwm[i]) e.hi++;
        e.per = k - m_start;
        e.dir = m_dir[m_start];
        exp_q.push_back(e);
      end
      have_start = 1'b1;
      m_start    = k;
    end
  endtask

  task automatic model_check();
    int   n;
    logic exp_v;
    n     = m_pwm.size() - 1;
    exp_v = 1'b0;
    if (rd < exp_q.size() && exp_q[rd].at == n) begin
      exp_v    = 1'b1;
      hold_hi  = exp_q[rd].hi;
      hold_per = exp_q[rd].per;
      hold_dir = exp_q[rd].dir;
      rd++;
    end
    check("model", {timeout, sample_valid, dir_out, period_cnt, high_cnt},
          {1'b0, exp_v, hold_dir, CNT_W'(hold_per), CNT_W'(hold_hi)});
  endtask

  // Advance n clock edges; inputs set before the call are sampled at the next edge,
  // outputs are read 2 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      if (model_on && rst_n) model_push(pwm_in, dir_in);
      @(posedge clk);
      #2;
      cyc++;
      if (sample_valid) begin
        if (last_valid) btb++;
        str_cyc.push_back(cyc);
        str_hi.push_back(int'(high_cnt));
        str_per.push_back(int'(period_cnt));
        str_dir.push_back(dir_out);
      end
      last_valid = sample_valid;
      if (model_on && rst_n) model_check();
    end
  endtask

  task automatic do_reset(input logic lvl);
    rst_n  = 1'b0;
    pwm_in = lvl;
    dir_in = 2'b00;
    model_clear();
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic period(input int h, input int l, input logic [1:0] d);
    pwm_in = 1'b1;
    dir_in = d;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, m, n0, cnt, hh, ll;
    logic [1:0] d;

    vecs[0] = '{h: 3,  l: 7,  dir: 2'b01, reps: 5, exp_hi: 3,  exp_per: 10};
    vecs[1] = '{h: 1,  l: 1,  dir: 2'b10, reps: 6, exp_hi: 1,  exp_per: 2};
    vecs[2] = '{h: 1,  l: 49, dir: 2'b11, reps: 3, exp_hi: 1,  exp_per: 50};
    vecs[3] = '{h: 49, l: 1,  dir: 2'b00, reps: 3, exp_hi: 49, exp_per: 50};
    vecs[4] = '{h: 12, l: 5,  dir: 2'b10, reps: 4, exp_hi: 12, exp_per: 17};

    // Reset state.
    tick(2);
    check("reset_outputs", {high_cnt, period_cnt, dir_out, sample_valid, timeout, stuck_level}, '0);

    // Periodic waveforms from a table.
    foreach (vecs[v]) begin
      do_reset(1'b0);
      tick(4);
      base = str_cyc.size();
      t0   = cyc;
      for (int r = 0; r < vecs[v].reps; r++) period(vecs[v].h, vecs[v].l, vecs[v].dir);
      pwm_in = 1'b1;
      tick(3);
      cnt = str_cyc.size() - base;
      check($sformatf("tbl%0d_count", v), cnt, vecs[v].reps);
      for (int j = 0; j < cnt; j++) begin
        check($sformatf("tbl%0d_cycle%0d", v, j), str_cyc[base+j],
              t0 + (j + 1) * (vecs[v].h + vecs[v].l) + 3);
        check($sformatf("tbl%0d_value%0d", v, j), {str_dir[base+j], str_per[base+j], str_hi[base+j]},
              {vecs[v].dir, vecs[v].exp_per, vecs[v].exp_hi});
      end
    end

    // Direction changed mid-period shows up one report later.
    do_reset(1'b0);
    tick(4);
    period(3, 7, 2'b01);
    pwm_in = 1'b1;
    m = cyc;
    tick(3);
    check("dir_first_latency", str_cyc[str_cyc.size()-1], m + 3);
    check("dir_first", str_dir[str_dir.size()-1], 2'b01);
    pwm_in = 1'b0;
    tick(3);
    dir_in = 2'b10;
    tick(4);
    pwm_in = 1'b1;
    tick(3);
    check("dir_changed_period", {str_dir[str_dir.size()-1], str_per[str_per.size()-1]}, {2'b01, 32'd10});
    pwm_in = 1'b0;
    tick(7);
    pwm_in = 1'b1;
    tick(3);
    check("dir_next_period", str_dir[str_dir.size()-1], 2'b10);

    // Line stuck high after toggling, then recovery.
    do_reset(1'b0);
    tick(4);
    repeat (3) period(3, 7, 2'b00);
    pwm_in = 1'b1;
    m = cyc;
    tick(3);
    n0 = str_cyc.size();
    tick(49);
    check("stuck_hi_before", timeout, 1'b0);
    tick(1);
    check("stuck_hi_flag", {timeout, stuck_level}, 2'b11);
    tick(20);
    check("stuck_hi_no_strobe", str_cyc.size(), n0);
    check("stuck_hi_holds", timeout, 1'b1);
    pwm_in = 1'b0;
    tick(2);
    check("stuck_hi_pre_fall", timeout, 1'b1);
    tick(1);
    check("stuck_hi_cleared", timeout, 1'b0);
    tick(4);
    period(3, 7, 2'b11);
    check("stuck_hi_first_rise_silent", str_cyc.size(), n0);
    pwm_in = 1'b1;
    m = cyc;
    tick(3);
    check("stuck_hi_recover_count", str_cyc.size(), n0 + 1);
    check("stuck_hi_recover_cycle", str_cyc[str_cyc.size()-1], m + 3);
    check("stuck_hi_recover_value", {str_dir[str_dir.size()-1], str_per[str_per.size()-1], str_hi[str_hi.size()-1]},
          {2'b11, 32'd10, 32'd3});

    // Period of TIMEOUT+1 (stuck low), then exit on a rise without publishing.
    do_reset(1'b0);
    tick(4);
    n0 = str_cyc.size();
    pwm_in = 1'b1;
    tick(1);
    pwm_in = 1'b0;
    tick(50);
    pwm_in = 1'b1;
    tick(1);
    check("stuck_lo_before", timeout, 1'b0);
    tick(1);
    check("stuck_lo_flag", {timeout, stuck_level}, 2'b10);
    tick(1);
    check("stuck_lo_rise_exit", timeout, 1'b0);
    check("stuck_lo_no_strobe", str_cyc.size(), n0);
    pwm_in = 1'b0;
    tick(7);
    pwm_in = 1'b1;
    tick(3);
    check("stuck_lo_next_value", {str_cyc.size(), str_per[str_per.size()-1], str_hi[str_hi.size()-1]},
          {n0 + 1, 32'd10, 32'd3});

    // pwm held high through reset release: no rise, timeout from IDLE.
    rst_n  = 1'b0;
    pwm_in = 1'b1;
    tick(3);
    n0 = str_cyc.size();
    rst_n = 1'b1;
    tick(50);
    check("rst_high_before", timeout, 1'b0);
    tick(1);
    check("rst_high_flag", {timeout, stuck_level}, 2'b11);
    check("rst_high_no_strobe", str_cyc.size(), n0);

    // Asynchronous reset in the middle of a high phase.
    do_reset(1'b0);
    tick(4);
    repeat (3) period(3, 7, 2'b11);
    pwm_in = 1'b1;
    tick(6);
    check("midrst_pre", {high_cnt, period_cnt, dir_out}, {8'd3, 8'd10, 2'b11});
    #1 rst_n = 1'b0;
    #1 check("midrst_async_zero", {high_cnt, period_cnt, dir_out, sample_valid, timeout, stuck_level}, '0);
    tick(2);
    rst_n = 1'b1;
    n0 = str_cyc.size();
    tick(4);
    pwm_in = 1'b0;
    tick(6);
    pwm_in = 1'b1;
    dir_in = 2'b10;
    tick(4);
    pwm_in = 1'b0;
    tick(6);
    check("midrst_first_rise_silent", str_cyc.size(), n0);
    pwm_in = 1'b1;
    m = cyc;
    tick(3);
    check("midrst_count", str_cyc.size(), n0 + 1);
    check("midrst_cycle", str_cyc[str_cyc.size()-1], m + 3);
    check("midrst_value", {str_dir[str_dir.size()-1], str_per[str_per.size()-1], str_hi[str_hi.size()-1]},
          {2'b10, 32'd10, 32'd4});

    // Random waveforms against the reference model.
    model_on = 1'b1;
    do_reset(1'($urandom_range(0, 1)));
    base = str_cyc.size();
    tick($urandom_range(1, 10));
    pwm_in = 1'b0;
    tick($urandom_range(1, 10));
    for (int i = 0; i < 40; i++) begin
      hh = $urandom_range(1, 20);
      ll = $urandom_range(1, 20);
      d  = 2'($urandom_range(0, 3));
      pwm_in = 1'b1;
      dir_in = d;
      tick(hh);
      pwm_in = 1'b0;
      if (ll > 1 && $urandom_range(0, 1) == 1) begin
        tick(1);
        dir_in = 2'($urandom_range(0, 3));
        tick(ll - 1);
      end else begin
        tick(ll);
      end
    end
    pwm_in = 1'b1;
    tick(3);
    check("model_drained", rd, exp_q.size());
    check("model_strobe_count", str_cyc.size() - base, exp_q.size());
    model_on = 1'b0;

    check("no_back_to_back", btb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
